// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one registered 8x8 Dadda multiplier; optional RSP_OVF via MUL_SHARE_ARB_OVF_EN
module mul_share_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 1,
    parameter bit PRIO_INIT   = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    REQ0_VALID,
    output logic                    REQ0_READY,
    input  logic [DATA_WIDTH-1:0]   REQ0_A,
    input  logic [DATA_WIDTH-1:0]   REQ0_B,
    input  logic                    REQ1_VALID,
    output logic                    REQ1_READY,
    input  logic [DATA_WIDTH-1:0]   REQ1_A,
    input  logic [DATA_WIDTH-1:0]   REQ1_B,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic                    RSP_ID,
    output logic [2*DATA_WIDTH-1:0] RSP_Y,
`ifdef MUL_SHARE_ARB_OVF_EN
    output logic                    RSP_OVF,
`endif
    output logic                    BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        prio;
    logic [3:0]  cnt;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_id;
    logic [15:0] mul_y;
    logic        grant_any;
    logic        grant_id;

    // Dadda column compression: heights 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
    // Each column is a packed bit bag consumed from bit 0 upward; carries land in the next column
    // before it is processed, so every stage honours the target height.
    function automatic logic [15:0] dadda_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] col [16];
        int          h   [16];
        logic [15:0] nc  [16];
        int          nh  [16];
        int          tgt;
        int          tot;
        logic        s;
        logic        cy;
        logic [15:0] r0;
        logic [15:0] r1;
        for (int c = 0; c < 16; c++) begin
            col[c] = '0;
            h[c]   = 0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[i+j] = col[i+j] | (16'(a[i] & b[j]) << h[i+j]);
                h[i+j]   = h[i+j] + 1;
            end
        end
        for (int st = 0; st < 4; st++) begin
            tgt = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
            for (int c = 0; c < 16; c++) begin
                nc[c] = '0;
                nh[c] = 0;
            end
            for (int c = 0; c < 16; c++) begin
                tot = h[c] + nh[c];
                while (tot > tgt) begin
                    if (tot > tgt + 1) begin
                        s      = col[c][0] ^ col[c][1] ^ col[c][2];
                        cy     = (col[c][0] & col[c][1]) | (col[c][0] & col[c][2]) | (col[c][1] & col[c][2]);
                        col[c] = col[c] >> 3;
                        h[c]   = h[c] - 3;
                        tot    = tot - 2;
                    end else begin
                        s      = col[c][0] ^ col[c][1];
                        cy     = col[c][0] & col[c][1];
                        col[c] = col[c] >> 2;
                        h[c]   = h[c] - 2;
                        tot    = tot - 1;
                    end
                    nc[c] = nc[c] | (16'(s) << nh[c]);
                    nh[c] = nh[c] + 1;
                    if (c < 15) begin
                        nc[c+1] = nc[c+1] | (16'(cy) << nh[c+1]);
                        nh[c+1] = nh[c+1] + 1;
                    end
                end
                nc[c] = nc[c] | (col[c] << nh[c]);
                nh[c] = nh[c] + h[c];
            end
            for (int c = 0; c < 16; c++) begin
                col[c] = nc[c];
                h[c]   = nh[c];
            end
        end
        for (int c = 0; c < 16; c++) begin
            r0[c] = col[c][0];
            r1[c] = col[c][1];
        end
        return r0 + r1;
    endfunction

    // Multiplier sees only the operand registers, so request-port changes never disturb a result
    assign mul_y = dadda_mul(op_a, op_b);

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        grant_any = REQ0_VALID | REQ1_VALID;
        grant_id  = (REQ0_VALID & REQ1_VALID) ? prio : REQ1_VALID;
    end

    assign REQ0_READY = RESET_N & (state == IDLE) & grant_any & ~grant_id;
    assign REQ1_READY = RESET_N & (state == IDLE) & grant_any & grant_id;
    assign RSP_VALID  = (state == RESP);
    assign BUSY       = (state != IDLE);

    // Accept, settle, capture and hand back one operation at a time
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= IDLE;
            prio    <= PRIO_INIT;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= 1'b0;
            RSP_ID  <= 1'b0;
            RSP_Y   <= '0;
`ifdef MUL_SHARE_ARB_OVF_EN
            RSP_OVF <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a  <= grant_id ? REQ1_A : REQ0_A;
                        op_b  <= grant_id ? REQ1_B : REQ0_B;
                        op_id <= grant_id;
                        prio  <= ~grant_id;
                        cnt   <= 4'(HOLD_CYCLES - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        RSP_Y   <= mul_y;
                        RSP_ID  <= op_id;
`ifdef MUL_SHARE_ARB_OVF_EN
                        RSP_OVF <= (mul_y[15:8] != 8'd0);
`endif
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed, table-driven self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REQ0_VALID;
    logic [7:0]  REQ0_A;
    logic [7:0]  REQ0_B;
    logic        REQ1_VALID;
    logic [7:0]  REQ1_A;
    logic [7:0]  REQ1_B;
    logic        RSP_READY;

    logic        d1_ready0, d1_ready1, d1_rsp_valid, d1_rsp_id, d1_busy;
    logic [15:0] d1_rsp_y;
    logic        d4_ready0, d4_ready1, d4_rsp_valid, d4_rsp_id, d4_busy;
    logic [15:0] d4_rsp_y;
`ifdef MUL_SHARE_ARB_OVF_EN
    logic        d1_rsp_ovf, d4_rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    vec_t vecs [10];

    logic        q_id [$];
    logic [15:0] q_y  [$];
    int          viol;
    int          seen;

    always #5 CLK = ~CLK;

    mul_share_arbiter #(.DATA_WIDTH(8), .HOLD_CYCLES(1), .PRIO_INIT(1'b0)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(d1_ready0), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(d1_ready1), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .RSP_VALID(d1_rsp_valid), .RSP_READY(RSP_READY), .RSP_ID(d1_rsp_id), .RSP_Y(d1_rsp_y),
`ifdef MUL_SHARE_ARB_OVF_EN
        .RSP_OVF(d1_rsp_ovf),
`endif
        .BUSY(d1_busy)
    );

    mul_share_arbiter #(.DATA_WIDTH(8), .HOLD_CYCLES(4), .PRIO_INIT(1'b0)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(d4_ready0), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(d4_ready1), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .RSP_VALID(d4_rsp_valid), .RSP_READY(RSP_READY), .RSP_ID(d4_rsp_id), .RSP_Y(d4_rsp_y),
`ifdef MUL_SHARE_ARB_OVF_EN
        .RSP_OVF(d4_rsp_ovf),
`endif
        .BUSY(d4_busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        RSP_READY  = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        idle_inputs();
        tick();
        RESET_N = 1'b1;
    endtask

    // One isolated operation through dut1 (HOLD_CYCLES=1), starting in IDLE
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] y);
        REQ0_VALID = ~id;
        REQ1_VALID = id;
        REQ0_A = id ? 8'd3 : a;
        REQ0_B = id ? 8'd3 : b;
        REQ1_A = id ? a : 8'd7;
        REQ1_B = id ? b : 8'd7;
        #1;
        check("op_ready_granted", id ? d1_ready1 : d1_ready0, 1);
        check("op_ready_other", id ? d1_ready0 : d1_ready1, 0);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        REQ0_A = 8'hFF; REQ0_B = 8'hFF; REQ1_A = 8'hFF; REQ1_B = 8'hFF;
        check("op_busy_calc", d1_busy, 1);
        check("op_valid_calc", d1_rsp_valid, 0);
        tick();
        check("op_valid_resp", d1_rsp_valid, 1);
        check("op_y", d1_rsp_y, y);
        check("op_id", d1_rsp_id, id);
`ifdef MUL_SHARE_ARB_OVF_EN
        check("op_ovf", d1_rsp_ovf, (y[15:8] != 8'd0));
`endif
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        check("op_valid_after", d1_rsp_valid, 0);
        check("op_busy_after", d1_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0,   8'd5,   8'd6,    16'd30};
        vecs[1] = '{1'b1,  8'd12,  8'd11,   16'd132};
        vecs[2] = '{1'b0, 8'd255, 8'd255, 16'd65025};
        vecs[3] = '{1'b1,  8'd16,  8'd16,   16'd256};
        vecs[4] = '{1'b0,  8'd15,  8'd17,   16'd255};
        vecs[5] = '{1'b1,   8'd0, 8'd200,     16'd0};
        vecs[6] = '{1'b0,   8'd1, 8'd255,   16'd255};
        vecs[7] = '{1'b1, 8'd128,   8'd2,   16'd256};
        vecs[8] = '{1'b0, 8'd170,  8'd85, 16'd14450};
        vecs[9] = '{1'b1, 8'd254,   8'd3,   16'd762};

        // Reset with both requesters asserting
        RESET_N = 1'b0;
        RSP_READY = 1'b0;
        REQ0_VALID = 1'b1; REQ0_A = 8'd9; REQ0_B = 8'd9;
        REQ1_VALID = 1'b1; REQ1_A = 8'd8; REQ1_B = 8'd8;
        tick();
        tick();
        check("rst_rsp_valid", d1_rsp_valid, 0);
        check("rst_rsp_y", d1_rsp_y, 0);
        check("rst_busy", d1_busy, 0);
        check("rst_ready0_low", d1_ready0, 0);
        check("rst_ready1_low", d1_ready1, 0);
        RESET_N = 1'b1;
        #1;
        check("rel_ready0", d1_ready0, 1);
        check("rel_ready1", d1_ready1, 0);
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        tick();
        check("idle_no_req_busy", d1_busy, 0);

        // Table of isolated operations
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].y);
        end

        // Contention: both requesters held, consumer always ready
        do_reset();
        REQ0_VALID = 1'b1; REQ0_A = 8'd255; REQ0_B = 8'd255;
        REQ1_VALID = 1'b1; REQ1_A = 8'd12;  REQ1_B = 8'd11;
        RSP_READY = 1'b1;
        #1;
        viol = 0;
        for (int k = 0; k < 15; k++) begin
            if (d1_rsp_valid && RSP_READY) begin
                q_id.push_back(d1_rsp_id);
                q_y.push_back(d1_rsp_y);
            end
            if (d1_busy && (d1_ready0 || d1_ready1)) viol++;
            if (d1_ready0 && d1_ready1) viol++;
            tick();
        end
        idle_inputs();
        check("cont_ready_while_busy", viol, 0);
        check("cont_resp_count", q_id.size(), 5);
        if (q_id.size() >= 3) begin
            check("cont_r0_id", q_id[0], 0);
            check("cont_r0_y", q_y[0], 65025);
            check("cont_r1_id", q_id[1], 1);
            check("cont_r1_y", q_y[1], 132);
            check("cont_r2_id", q_id[2], 0);
            check("cont_r2_y", q_y[2], 65025);
        end

        // Backpressure in RESP
        do_reset();
        REQ0_VALID = 1'b1; REQ0_A = 8'd7; REQ0_B = 8'd9;
        RSP_READY = 1'b1;
        tick();
        check("bp_calc_ready_no_effect", d1_busy, 1);
        RSP_READY = 1'b0;
        REQ0_VALID = 1'b1; REQ0_A = 8'd100; REQ0_B = 8'd100;
        REQ1_VALID = 1'b1; REQ1_A = 8'd50;  REQ1_B = 8'd50;
        tick();
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            if (d1_rsp_valid !== 1'b1) viol++;
            if (d1_rsp_y !== 16'd63) viol++;
            if (d1_rsp_id !== 1'b0) viol++;
            if (d1_ready0 || d1_ready1) viol++;
            tick();
        end
        check("bp_hold_stable", viol, 0);
        RSP_READY = 1'b1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        tick();
        RSP_READY = 1'b0;
        check("bp_valid_drop", d1_rsp_valid, 0);
        check("bp_busy_drop", d1_busy, 0);
        check("bp_y_hold", d1_rsp_y, 63);

        // HOLD_CYCLES=4 latency
        do_reset();
        REQ0_VALID = 1'b1; REQ0_A = 8'd3; REQ0_B = 8'd4;
        #1;
        check("h4_ready0", d4_ready0, 1);
        tick();
        REQ0_VALID = 1'b0;
        viol = 0;
        for (int k = 0; k < 4; k++) begin
            if (d4_rsp_valid !== 1'b0) viol++;
            if (d4_ready0 || d4_ready1) viol++;
            tick();
        end
        check("h4_early_valid", viol, 0);
        check("h4_valid", d4_rsp_valid, 1);
        check("h4_y", d4_rsp_y, 12);
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        check("h4_valid_drop", d4_rsp_valid, 0);

        // Reset in the second CALC cycle drops the operation
        REQ0_VALID = 1'b1; REQ0_A = 8'd9; REQ0_B = 8'd9;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        check("mid_busy_calc", d4_busy, 1);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check("mid_busy", d4_busy, 0);
        check("mid_y", d4_rsp_y, 0);
        viol = 0;
        for (int k = 0; k < 6; k++) begin
            if (d4_rsp_valid !== 1'b0) viol++;
            tick();
        end
        check("mid_no_resp", viol, 0);
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        #1;
        check("mid_tie_ready0", d4_ready0, 1);
        check("mid_tie_ready1", d4_ready1, 0);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
